// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter that shares one MM register bus among NUM_REQ requesters,
// issuing one transaction at a time and routing read responses back with a timeout.
//
// state   | meaning
// IDLE    | waiting for a request; grant issued combinationally
// ISSUE   | MM write or read strobe driven for one cycle
// RD_WAIT | waiting for the decoder's read response or the timeout
module mm_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        iREQ,
  input  logic [NUM_REQ-1:0]        iREQ_WR,
  input  logic [NUM_REQ*ADDR_W-1:0] iREQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] iREQ_WDATA,
  output logic [NUM_REQ-1:0]        oGNT,
  output logic [DATA_W-1:0]         oRD_DATA,
  output logic [NUM_REQ-1:0]        oRD_DATA_V,
  output logic [NUM_REQ-1:0]        oRD_ERR,
  output logic                      oSPURIOUS,
  output logic                      oMM_WR_EN,
  output logic                      oMM_RD_EN,
  output logic [ADDR_W-1:0]         oMM_ADDR,
  output logic [DATA_W-1:0]         oMM_WR_DATA,
  input  logic [DATA_W-1:0]         iMM_RD_DATA,
  input  logic                      iMM_RD_DATA_V
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur_g;
  logic [CNT_W-1:0]   cnt;

  logic               found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NUM_REQ-1:0] cur_onehot;
  int                 idx;

  // Search starts at the pointer and wraps; grant is suppressed while in reset.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    oGNT    = '0;
    if (state == S_IDLE && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && iREQ[idx]) begin
          found   = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
      if (found) oGNT[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_next   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    sel_addr   = iREQ_ADDR[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata  = iREQ_WDATA[int'(gnt_idx)*DATA_W +: DATA_W];
    cur_onehot = '0;
    cur_onehot[cur_g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cur_g       <= '0;
      cnt         <= '0;
      oRD_DATA    <= '0;
      oRD_DATA_V  <= '0;
      oRD_ERR     <= '0;
      oSPURIOUS   <= 1'b0;
      oMM_WR_EN   <= 1'b0;
      oMM_RD_EN   <= 1'b0;
      oMM_ADDR    <= '0;
      oMM_WR_DATA <= '0;
    end else begin
      oMM_WR_EN  <= 1'b0;
      oMM_RD_EN  <= 1'b0;
      oRD_DATA_V <= '0;
      oRD_ERR    <= '0;
      if (iMM_RD_DATA_V && state != S_RD_WAIT) oSPURIOUS <= 1'b1;
      case (state)
        S_IDLE: begin
          if (found) begin
            cur_g       <= gnt_idx;
            oMM_WR_EN   <= iREQ_WR[gnt_idx];
            oMM_RD_EN   <= !iREQ_WR[gnt_idx];
            oMM_ADDR    <= sel_addr;
            oMM_WR_DATA <= sel_wdata;
            ptr         <= ptr_next;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The write strobe itself tells us which kind of transaction is in flight.
          if (oMM_WR_EN) begin
            state <= S_IDLE;
          end else begin
            cnt   <= '0;
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (iMM_RD_DATA_V) begin
            oRD_DATA   <= iMM_RD_DATA;
            oRD_DATA_V <= cur_onehot;
            state      <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            oRD_DATA   <= ERR_DATA;
            oRD_DATA_V <= cur_onehot;
            oRD_ERR    <= cur_onehot;
            state      <= S_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Scoreboard bench for mm_bus_arbiter: stimulus queues expected grants, MM strobes
// and read responses with their cycle numbers; a negedge monitor pops and compares.
module tb_mm_bus_arbiter;

  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req, req_wr;
  logic [33:0]  req_addr;
  logic [127:0] req_wdata;
  logic [1:0]   gnt, rd_v, rd_err;
  logic [63:0]  rd_data, mm_wdata, mm_rdata;
  logic         spurious, mm_wr, mm_rd, mm_rv;
  logic [16:0]  mm_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          idx;
    logic        wr;
    logic        err;
    logic [16:0] addr;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  ev_t gnt_q[$];
  ev_t mm_q[$];
  ev_t rsp_q[$];

  mm_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .iREQ(req), .iREQ_WR(req_wr), .iREQ_ADDR(req_addr), .iREQ_WDATA(req_wdata),
    .oGNT(gnt), .oRD_DATA(rd_data), .oRD_DATA_V(rd_v), .oRD_ERR(rd_err),
    .oSPURIOUS(spurious), .oMM_WR_EN(mm_wr), .oMM_RD_EN(mm_rd),
    .oMM_ADDR(mm_addr), .oMM_WR_DATA(mm_wdata),
    .iMM_RD_DATA(mm_rdata), .iMM_RD_DATA_V(mm_rv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [16:0] a, input logic [63:0] d);
    req_wr[i] = wr;
    req_addr[i*17 +: 17] = a;
    req_wdata[i*64 +: 64] = d;
    req[i] = 1'b1;
  endtask

  function automatic ev_t mk(input int idx, input logic wr, input logic err,
                             input logic [16:0] a, input logic [63:0] d, input int c);
    ev_t e;
    e.idx = idx; e.wr = wr; e.err = err; e.addr = a; e.data = d; e.cyc = c;
    return e;
  endfunction

  function automatic int onehot_idx(input logic [1:0] v);
    return v[1] ? 1 : 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
    chk({tag, "_rd_v"}, 64'(rd_v), 64'd0);
    chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    chk({tag, "_spurious"}, 64'(spurious), 64'd0);
    chk({tag, "_mm_en"}, 64'({mm_wr, mm_rd}), 64'd0);
    chk({tag, "_mm_addr"}, 64'(mm_addr), 64'd0);
    chk({tag, "_mm_wdata"}, mm_wdata, 64'd0);
  endtask

  // Monitor: compare every DUT-presented event against the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (gnt != 2'b00) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
      else begin
        e = gnt_q.pop_front();
        chk("gnt_onehot", 64'($countones(gnt)), 64'd1);
        chk("gnt_idx", 64'(onehot_idx(gnt)), 64'(e.idx));
        chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mm_wr || mm_rd) begin
      if (mm_q.size() == 0) chk("mm_unexpected", 64'({mm_wr, mm_rd}), 64'd0);
      else begin
        e = mm_q.pop_front();
        chk("mm_wr_en", 64'(mm_wr), 64'(e.wr));
        chk("mm_rd_en", 64'(mm_rd), 64'(!e.wr));
        chk("mm_addr", 64'(mm_addr), 64'(e.addr));
        if (e.wr) chk("mm_wdata", mm_wdata, e.data);
        chk("mm_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rd_v != 2'b00) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rd_v), 64'd0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_idx", 64'(rd_v), 64'(2'b01 << e.idx));
        chk("rsp_data", rd_data, e.data);
        chk("rsp_err", 64'(rd_err), e.err ? 64'(2'b01 << e.idx) : 64'd0);
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (rd_err != 2'b00) begin
      chk("err_without_valid", 64'(rd_err), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    mm_rdata = '0; mm_rv = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single write from requester 0.
    c = cyc;
    set_req(0, 1'b1, 17'h08010, 64'h1234);
    gnt_q.push_back(mk(0, 1'b1, 1'b0, 17'h08010, 64'h1234, c));
    mm_q.push_back(mk(0, 1'b1, 1'b0, 17'h08010, 64'h1234, c + 1));
    tick(); req = '0;
    tick();

    // Read to unmapped address, next grant two cycles after the write grant.
    c = cyc;
    set_req(0, 1'b0, 17'h18000, 64'h0);
    gnt_q.push_back(mk(0, 1'b0, 1'b0, 17'h18000, 64'h0, c));
    mm_q.push_back(mk(0, 1'b0, 1'b0, 17'h18000, 64'h0, c + 1));
    rsp_q.push_back(mk(0, 1'b0, 1'b0, 17'h0, 64'h5555_AAAA_0001_8000, c + 5));
    tick(); req = '0;
    while (cyc < c + 4) tick();
    mm_rdata = 64'h5555_AAAA_0001_8000; mm_rv = 1'b1;
    tick(); mm_rv = 1'b0;
    tick();

    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Both requesters writing continuously: 0,1,0,1 every 2 cycles.
    c = cyc;
    set_req(0, 1'b1, 17'h00100, 64'hA0);
    set_req(1, 1'b1, 17'h00200, 64'hB1);
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(mk(k % 2, 1'b1, 1'b0, 17'h0, 64'h0, c + 2*k));
      mm_q.push_back(mk(k % 2, 1'b1, 1'b0, (k % 2) ? 17'h00200 : 17'h00100,
                        (k % 2) ? 64'hB1 : 64'hA0, c + 2*k + 1));
    end
    repeat (7) tick();
    req = '0;
    tick();

    // Read from requester 1 with no response: timeout then a late spurious response.
    c = cyc;
    set_req(1, 1'b0, 17'h00300, 64'h0);
    gnt_q.push_back(mk(1, 1'b0, 1'b0, 17'h0, 64'h0, c));
    mm_q.push_back(mk(1, 1'b0, 1'b0, 17'h00300, 64'h0, c + 1));
    rsp_q.push_back(mk(1, 1'b0, 1'b1, 17'h0, ERR, c + 66));
    tick(); req = '0;
    while (cyc < c + 76) tick();
    chk("spurious_before_late", 64'(spurious), 64'd0);
    mm_rdata = 64'h77; mm_rv = 1'b1;
    tick(); mm_rv = 1'b0;
    chk("spurious_after_late", 64'(spurious), 64'd1);
    chk("rd_data_hold", rd_data, ERR);
    tick();

    // Response exactly on the timeout boundary is a good completion.
    c = cyc;
    set_req(0, 1'b0, 17'h00400, 64'h0);
    gnt_q.push_back(mk(0, 1'b0, 1'b0, 17'h0, 64'h0, c));
    mm_q.push_back(mk(0, 1'b0, 1'b0, 17'h00400, 64'h0, c + 1));
    rsp_q.push_back(mk(0, 1'b0, 1'b0, 17'h0, 64'h0123_4567_89AB_CDEF, c + 66));
    tick(); req = '0;
    while (cyc < c + 65) tick();
    mm_rdata = 64'h0123_4567_89AB_CDEF; mm_rv = 1'b1;
    tick(); mm_rv = 1'b0;
    tick();

    // Reset while in RD_WAIT abandons the read.
    c = cyc;
    set_req(1, 1'b0, 17'h00500, 64'h0);
    gnt_q.push_back(mk(1, 1'b0, 1'b0, 17'h0, 64'h0, c));
    mm_q.push_back(mk(1, 1'b0, 1'b0, 17'h00500, 64'h0, c + 1));
    tick(); req = '0;
    while (cyc < c + 5) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(); rst_n = 1'b1;
    while (cyc < c + 8) tick();
    mm_rdata = 64'h99; mm_rv = 1'b1;
    tick(); mm_rv = 1'b0;
    chk("spurious_after_reset", 64'(spurious), 64'd1);
    chk("rd_data_not_routed", rd_data, 64'd0);
    tick();
    c = cyc;
    set_req(0, 1'b1, 17'h00600, 64'h66);
    set_req(1, 1'b1, 17'h00700, 64'h77);
    gnt_q.push_back(mk(0, 1'b1, 1'b0, 17'h0, 64'h0, c));
    mm_q.push_back(mk(0, 1'b1, 1'b0, 17'h00600, 64'h66, c + 1));
    tick(); req = '0;
    repeat (4) tick();

    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    chk("mm_q_drained", 64'(mm_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_bus_arbiter.md
Name: mm_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MM register bus (17-bit address, 64-bit data) among NUM_REQ requesters, e.g. host PCIe bridge and internal BIST/DMA engines.
- Drives the MM inputs of the link address decoder (iMM_WR_EN, iMM_RD_EN, iMM_ADDR, iMM_WR_DATA) and consumes its oMM_RD_DATA/oMM_RD_DATA_V.
- Allows one transaction in flight at a time.
- Routes each read response back to the requester that issued the read, with a timeout for reads that never complete.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 17, MM address width
DATA_W, 64, MM data width
TIMEOUT, 64, RD_WAIT cycles without response before an error completion (1..1023)
ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data returned on timeout

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
iREQ  input  NUM_REQ  per-requester request; held until granted
iREQ_WR  input  NUM_REQ  1=write, 0=read
iREQ_ADDR  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
iREQ_WDATA  input  NUM_REQ*DATA_W  flattened write data
oGNT  output  NUM_REQ  one-hot, one-cycle grant; command captured this cycle
oRD_DATA  output  DATA_W  shared read-response data
oRD_DATA_V  output  NUM_REQ  one-hot, one-cycle read-response valid
oRD_ERR  output  NUM_REQ  one-cycle timeout flag, coincident with oRD_DATA_V
oSPURIOUS  output  1  sticky: response seen with no read outstanding
oMM_WR_EN  output  1  to decoder iMM_WR_EN
oMM_RD_EN  output  1  to decoder iMM_RD_EN
oMM_ADDR  output  ADDR_W  to decoder iMM_ADDR
oMM_WR_DATA  output  DATA_W  to decoder iMM_WR_DATA
iMM_RD_DATA  input  DATA_W  from decoder oMM_RD_DATA
iMM_RD_DATA_V  input  1  from decoder oMM_RD_DATA_V

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- Reset mid-transaction abandons the transaction; no response is ever produced for it.
- FSM states are IDLE, ISSUE, RD_WAIT.
- IDLE:
  - If any iREQ is set, oGNT[g] is driven combinationally for the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - In the same cycle: capture g, WR, ADDR and WDATA; pointer <= (g+1) mod NUM_REQ; go to ISSUE.
  - No request: oGNT = 0, pointer holds.
- ISSUE:
  - Registered oMM_WR_EN or oMM_RD_EN is high for exactly this one cycle, with oMM_ADDR/oMM_WR_DATA from the captured values.
  - Write: next state IDLE. Write-to-next-grant spacing is 2 cycles. No write acknowledge is generated.
  - Read: clear the counter; next state RD_WAIT.
- Outside ISSUE: oMM_WR_EN = oMM_RD_EN = 0; oMM_ADDR and oMM_WR_DATA hold their last values.
- RD_WAIT, per cycle:
  - If iMM_RD_DATA_V: register oRD_DATA <= iMM_RD_DATA and pulse oRD_DATA_V[g] next cycle; go to IDLE.
  - Else if counter == TIMEOUT-1: next cycle oRD_DATA <= ERR_DATA with oRD_DATA_V[g] and oRD_ERR[g] both pulsed; go to IDLE.
  - Else counter += 1, saturating.
- A response arriving in the same cycle as the timeout boundary counts as a valid completion, not an error.
- Response latency: one cycle from iMM_RD_DATA_V to oRD_DATA_V.
- Grants from IDLE may coincide with the oRD_DATA_V pulse, since IDLE is entered that cycle.
- iMM_RD_DATA_V in IDLE or ISSUE, including late data after a timeout:
  - Ignored for routing.
  - Sets oSPURIOUS, which is cleared only by reset.
- oRD_DATA holds its last value between responses.
- iREQ dropped before grant is legal; that requester is simply not granted.
- Payload must be stable while iREQ=1.

Test Plan:
- Single write, requester 0, addr 17'h08010, data 64'h1234: oGNT[0] at T, oMM_WR_EN=1 at T+1 only with matching addr/data, IDLE at T+2.
- Read to an unmapped decoder address 17'h1_8000, decoder attached: grant at T, iMM_RD_DATA_V at T+4, oRD_DATA_V[0] at T+5 with data 64'h5555_AAAA_0001_8000.
- Both requesters asserting back-to-back writes continuously: grants alternate 0,1,0,1, every 2 cycles, starting with 0 after reset.
- Read with no response, TIMEOUT=64: oRD_DATA_V[1] and oRD_ERR[1] together, with oRD_DATA=ERR_DATA, 64 cycles into RD_WAIT. A decoder response injected 10 cycles later sets oSPURIOUS and produces no oRD_DATA_V.
- Response arriving in the exact timeout cycle: oRD_ERR stays 0 and the real data is returned.
- rst_n low for 1 cycle while in RD_WAIT: all outputs 0 immediately; a subsequent decoder response is not routed and only sets oSPURIOUS; next grant goes to requester 0.
